serv_ibus_fetch: RTL and testbench

Instruction-fetch stage directly upstream of serv_decode. On a fetch request from the control unit it runs one Wishbone-classic read on the instruction bus and captures the returned word. It then presents the word to decode as i_wb_rdt[31:2] with a one-cycle i_wb_en strobe. It also provides flush, a bus-timeout watchdog and detection of non-32-bit encodings.

---
 rtl/serv_ibus_fetch_pkg.sv | 16 +
 rtl/serv_ibus_fetch_if.sv | 10 +
 rtl/serv_ibus_fetch_wdog.sv | 37 +++
 rtl/serv_ibus_fetch.sv | 99 +++++++++
 tb/tb_serv_ibus_fetch.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serv_ibus_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package serv_fetch_pkg;

   // Fetch FSM states: waiting for a request, or running a bus read
   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_BUSY = 1'b1
   } fetch_state_e;

   // Low two bits of every 32-bit RISC-V encoding
   localparam logic [1:0] RV32_LEN_BITS = 2'b11;

   // Default bus-timeout in BUSY cycles (0 turns the watchdog off)
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/serv_ibus_fetch_if.sv
// Wishbone-classic read-only instruction bus (cyc and stb combined).
interface serv_ibus_fetch_if;
   logic [31:0] adr;
   logic        cyc;
   logic        ack;
   logic [31:0] rdt;

   modport master (output adr, output cyc, input ack, input rdt);
   modport slave  (input adr, input cyc, output ack, output rdt);
endinterface

// File: rtl/serv_ibus_fetch_wdog.sv
// Bus watchdog: counts BUSY cycles without ack and flags the cycle in
// which the count reaches TIMEOUT_CYCLES. Collapses to a constant 0
// when TIMEOUT_CYCLES is 0.
module serv_fetch_wdog #(
   parameter int WDOG_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         assign o_expire = 1'b0;
      end else begin : g_on
         // The count holds the number of completed waiting cycles, so the
         // current cycle is the last allowed one when it equals TIMEOUT-1.
         localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

         logic [WDOG_W-1:0] cnt;

         // Waiting-cycle counter, cleared while idle
         always_ff @(posedge clk) begin
            if (i_rst || i_clr)
               cnt <= '0;
            else if (i_run)
               cnt <= cnt + 1'b1;
         end

         assign o_expire = i_run && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/serv_ibus_fetch.sv
// Instruction fetch: one Wishbone read per request, word handed to decode
// as bits [31:2] with a one-cycle strobe; flush, bus timeout and
// non-32-bit encoding detection.
module serv_ibus_fetch
   import serv_fetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int WDOG_W         = 8
) (
   input  logic                      clk,
   input  logic                      i_rst,
   input  logic                      i_fetch,
   input  logic [29:0]               i_pc,
   input  logic                      i_flush,
   output logic                      o_ready,
   serv_ibus_fetch_if.master         ibus,
   output logic [29:0]               o_rdt,
   output logic                      o_en,
   output logic                      o_illegal,
   output logic                      o_bus_err
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [29:0]  pc_q;
   logic         accept;
   logic         capture;
   logic         abort;
   logic         wdog_run;
   logic         wdog_expire;

   // Watchdog runs only in BUSY cycles that neither complete nor flush
   assign wdog_run = (state_q == FETCH_BUSY) && !ibus.ack && !i_flush;

   serv_fetch_wdog #(
      .WDOG_W         (WDOG_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_clr    (state_q == FETCH_IDLE),
      .i_run    (wdog_run),
      .o_expire (wdog_expire)
   );

   // Next state and one-cycle actions; flush beats ack beats timeout
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state_q)
         FETCH_IDLE: begin
            if (i_fetch && !i_flush) begin
               state_d = FETCH_BUSY;
               accept  = 1'b1;
            end
         end
         FETCH_BUSY: begin
            if (i_flush) begin
               state_d = FETCH_IDLE;
            end else if (ibus.ack) begin
               state_d = FETCH_IDLE;
               capture = 1'b1;
            end else if (wdog_expire) begin
               state_d = FETCH_IDLE;
               abort   = 1'b1;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   // State, address and capture registers plus the output strobes
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q   <= FETCH_IDLE;
         pc_q      <= '0;
         o_rdt     <= '0;
         o_en      <= 1'b0;
         o_illegal <= 1'b0;
         o_bus_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         o_en      <= capture;
         o_illegal <= capture && (ibus.rdt[1:0] != RV32_LEN_BITS);
         o_bus_err <= abort;
         if (accept)
            pc_q <= i_pc;
         if (capture)
            o_rdt <= ibus.rdt[31:2];
      end
   end

   assign o_ready  = (state_q == FETCH_IDLE);
   assign ibus.cyc = (state_q == FETCH_BUSY);
   assign ibus.adr = {pc_q, 2'b00};

endmodule

// File: tb/tb_serv_ibus_fetch.sv
// Scoreboard bench: stimulus pushes expected decode/error strobes, a
// negedge monitor pops and compares them; cycle-level checks inline.
module tb_serv_ibus_fetch;
   import serv_fetch_pkg::*;

   typedef struct packed {
      logic        err;
      logic [29:0] rdt;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // DUT A: default watchdog
   logic        fetch_a = 1'b0;
   logic [29:0] pc_a    = '0;
   logic        flush_a = 1'b0;
   logic        ready_a, en_a, ill_a, err_a;
   logic [29:0] rdt_a;
   serv_ibus_fetch_if ifa ();

   // DUT B: short watchdog
   logic        fetch_b = 1'b0;
   logic [29:0] pc_b    = '0;
   logic        flush_b = 1'b0;
   logic        ready_b, en_b, ill_b, err_b;
   logic [29:0] rdt_b;
   serv_ibus_fetch_if ifb ();

   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t ea, eb;

   int checks = 0;
   int errors = 0;
   int mon_checks = 0;
   int mon_errors = 0;

   always #5 clk = ~clk;

   serv_ibus_fetch dut_a (
      .clk(clk), .i_rst(rst), .i_fetch(fetch_a), .i_pc(pc_a), .i_flush(flush_a),
      .o_ready(ready_a), .ibus(ifa), .o_rdt(rdt_a), .o_en(en_a),
      .o_illegal(ill_a), .o_bus_err(err_a)
   );

   serv_ibus_fetch #(.TIMEOUT_CYCLES(4), .WDOG_W(3)) dut_b (
      .clk(clk), .i_rst(rst), .i_fetch(fetch_b), .i_pc(pc_b), .i_flush(flush_b),
      .o_ready(ready_b), .ibus(ifb), .o_rdt(rdt_b), .o_en(en_b),
      .o_illegal(ill_b), .o_bus_err(err_b)
   );

   // Monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (en_a || err_a) begin
         mon_checks++;
         if (exp_a.size() == 0) begin
            mon_errors++;
            $display("FAIL mon_a unexpected strobe: en=%0b err=%0b rdt=%h", en_a, err_a, rdt_a);
         end else begin
            ea = exp_a.pop_front();
            if ({en_a, err_a, rdt_a, ill_a} !== {!ea.err, ea.err, ea.rdt, ea.ill}) begin
               mon_errors++;
               $display("FAIL mon_a strobe: got en=%0b err=%0b rdt=%h ill=%0b want en=%0b err=%0b rdt=%h ill=%0b",
                        en_a, err_a, rdt_a, ill_a, !ea.err, ea.err, ea.rdt, ea.ill);
            end
         end
      end
      if (en_b || err_b) begin
         mon_checks++;
         if (exp_b.size() == 0) begin
            mon_errors++;
            $display("FAIL mon_b unexpected strobe: en=%0b err=%0b rdt=%h", en_b, err_b, rdt_b);
         end else begin
            eb = exp_b.pop_front();
            if ({en_b, err_b, rdt_b, ill_b} !== {!eb.err, eb.err, eb.rdt, eb.ill}) begin
               mon_errors++;
               $display("FAIL mon_b strobe: got en=%0b err=%0b rdt=%h ill=%0b want en=%0b err=%0b rdt=%h ill=%0b",
                        en_b, err_b, rdt_b, ill_b, !eb.err, eb.err, eb.rdt, eb.ill);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One fetch on DUT A with 'wait_cyc' wait states before the ack
   task automatic fetch_a_run(input logic [29:0] pc, input int wait_cyc,
                              input logic [31:0] rdt, input logic extra);
      int hi;
      fetch_a = 1'b1;
      pc_a    = pc;
      cycle();
      fetch_a = 1'b0;
      hi = 0;
      for (int w = 0; w < wait_cyc; w++) begin
         if (ifa.cyc === 1'b1) hi++;
         chk("adr_stable", ifa.adr, {pc, 2'b00});
         fetch_a = extra && (w == 1);
         pc_a    = 30'h2AAA_AAAA;
         cycle();
         fetch_a = 1'b0;
      end
      if (ifa.cyc === 1'b1) hi++;
      ifa.ack = 1'b1;
      ifa.rdt = rdt;
      exp_a.push_back('{err: 1'b0, rdt: rdt[31:2], ill: (rdt[1:0] != RV32_LEN_BITS)});
      cycle();
      ifa.ack = 1'b0;
      ifa.rdt = 32'h0;
      chk("cyc_high_cycles", hi, wait_cyc + 1);
      chk("en_after_ack", {31'b0, en_a}, 32'h1);
      chk("ready_after_ack", {31'b0, ready_a}, 32'h1);
      chk("cyc_after_ack", {31'b0, ifa.cyc}, 32'h0);
      chk("adr_held", ifa.adr, {pc, 2'b00});
   endtask

   initial begin
      int hi;
      ifa.ack = 1'b0; ifa.rdt = '0;
      ifb.ack = 1'b0; ifb.rdt = '0;
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_ready", {31'b0, ready_a}, 32'h1);
      chk("rst_cyc", {31'b0, ifa.cyc}, 32'h0);
      chk("rst_adr", ifa.adr, 32'h0);
      chk("rst_rdt", {2'b0, rdt_a}, 32'h0);
      chk("rst_strobes", {29'b0, en_a, ill_a, err_a}, 32'h0);

      // 1: zero-wait fetch
      fetch_a_run(30'h0000_0040, 0, 32'h1230_0093, 1'b0);
      chk("t1_adr", ifa.adr, 32'h0000_0100);
      chk("t1_rdt", {2'b0, rdt_a}, 32'h048C_0024);

      // 2: five wait states, stray fetch during BUSY
      fetch_a_run(30'h0000_0100, 5, 32'h0000_0063, 1'b1);
      chk("t2_rdt", {2'b0, rdt_a}, 32'h0000_0018);
      cycle();
      chk("t2_no_second_cyc", {31'b0, ifa.cyc}, 32'h0);

      // 3: compressed / illegal encoding
      fetch_a_run(30'h0000_0104, 0, 32'h0000_4501, 1'b0);
      chk("t3_ill", {31'b0, ill_a}, 32'h1);
      chk("t3_rdt", {2'b0, rdt_a}, 32'h0000_1140);

      // 4: flush coincident with ack, then spurious ack in IDLE
      fetch_a = 1'b1; pc_a = 30'h0000_0200;
      cycle();
      fetch_a = 1'b0;
      ifa.ack = 1'b1; ifa.rdt = 32'hFFFF_FFFF; flush_a = 1'b1;
      cycle();
      ifa.ack = 1'b0; flush_a = 1'b0;
      chk("t4_cyc", {31'b0, ifa.cyc}, 32'h0);
      chk("t4_en", {31'b0, en_a}, 32'h0);
      chk("t4_ready", {31'b0, ready_a}, 32'h1);
      chk("t4_rdt_kept", {2'b0, rdt_a}, 32'h0000_1140);
      ifa.ack = 1'b1;
      cycle();
      ifa.ack = 1'b0;
      cycle();
      chk("t4_spurious_ack", {2'b0, rdt_a}, 32'h0000_1140);

      // 5a: watchdog expiry on DUT B
      fetch_b = 1'b1; pc_b = 30'h0000_0010;
      exp_b.push_back('{err: 1'b1, rdt: 30'h0, ill: 1'b0});
      cycle();
      fetch_b = 1'b0;
      hi = 0;
      for (int i = 0; i < 10 && ifb.cyc === 1'b1; i++) begin
         hi++;
         cycle();
      end
      chk("t5_busy_cycles", hi, 4);
      chk("t5_err", {31'b0, err_b}, 32'h1);
      chk("t5_no_en", {31'b0, en_b}, 32'h0);
      cycle();
      chk("t5_err_once", {31'b0, err_b}, 32'h0);
      chk("t5_cyc_low", {31'b0, ifb.cyc}, 32'h0);

      // 5b: ack in the 4th BUSY cycle wins over the timeout
      fetch_b = 1'b1;
      cycle();
      fetch_b = 1'b0;
      cycle();
      cycle();
      cycle();
      chk("t5b_cyc", {31'b0, ifb.cyc}, 32'h1);
      ifb.ack = 1'b1; ifb.rdt = 32'h0000_0013;
      exp_b.push_back('{err: 1'b0, rdt: 30'h4, ill: 1'b0});
      cycle();
      ifb.ack = 1'b0;
      chk("t5b_en", {31'b0, en_b}, 32'h1);
      chk("t5b_no_err", {31'b0, err_b}, 32'h0);

      // 6: reset mid-BUSY, then a normal fetch
      fetch_a = 1'b1; pc_a = 30'h0000_0300;
      cycle();
      fetch_a = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_cyc", {31'b0, ifa.cyc}, 32'h0);
      chk("t6_rdt", {2'b0, rdt_a}, 32'h0);
      chk("t6_en", {31'b0, en_a}, 32'h0);
      chk("t6_ready", {31'b0, ready_a}, 32'h1);
      fetch_a_run(30'h3FFF_FFFF, 1, 32'hDEAD_BEEF, 1'b0);
      chk("t6_adr", ifa.adr, 32'hFFFF_FFFC);
      chk("t6_rdt_after", {2'b0, rdt_a}, 32'h37AB_6FBB);

      cycle();
      cycle();
      chk("queue_a_drained", exp_a.size(), 0);
      chk("queue_b_drained", exp_b.size(), 0);
      checks += mon_checks;
      errors += mon_errors;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
